// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin share of the register-file
// write port with a one-cycle registered output stage and x0 drop.
module wb_port_arbiter #(
  parameter int NREQ  = 3,
  parameter int XLEN  = 32,
  parameter int RID_W = 5,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*RID_W-1:0] req_id,
  input  logic [NREQ*XLEN-1:0]  req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  enable_write,
  output logic [RID_W-1:0]      write_id,
  output logic [XLEN-1:0]       write_data,
  output logic [PW-1:0]         grant_idx,
  output logic [NREQ-1:0]       pending
);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic             found;
  logic             xfer;
  logic [RID_W-1:0] win_id;
  logic [XLEN-1:0]  win_data;
  logic [PW-1:0]    nxt_ptr;

  // Search upward from rr_ptr for the first valid requester.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Ready is one-hot on the winner, gated by hold and reset only.
  always_comb begin
    req_ready = '0;
    if (found && !hold && rst_n) begin
      req_ready[win] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Pick out the winner's destination and data.
  always_comb begin
    win_id   = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_id   = req_id[i*RID_W +: RID_W];
        win_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign nxt_ptr = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      enable_write <= 1'b0;
      write_id     <= '0;
      write_data   <= '0;
      grant_idx    <= '0;
      pending      <= '0;
    end else if (xfer) begin
      rr_ptr       <= nxt_ptr;
      enable_write <= (win_id != '0);
      write_id     <= win_id;
      write_data   <= win_data;
      grant_idx    <= win;
      pending      <= (win_id != '0) ? req_ready : '0;
    end else begin
      enable_write <= 1'b0;
      pending      <= '0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model
// predicts each cycle's output stage; a monitor pops and compares.
module tb_wb_port_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;
  localparam int RW = 5;

  typedef struct {
    logic          en;
    logic [RW-1:0] id;
    logic [XL-1:0] data;
    logic [1:0]    g;
    logic [N-1:0]  pend;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_id = '0;
  logic [N*XL-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            enable_write;
  logic [RW-1:0]   write_id;
  logic [XL-1:0]   write_data;
  logic [1:0]      grant_idx;
  logic [N-1:0]    pending;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NREQ(N), .XLEN(XL), .RID_W(RW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hold(hold),
    .req_valid(req_valid),
    .req_id(req_id),
    .req_data(req_data),
    .req_ready(req_ready),
    .enable_write(enable_write),
    .write_id(write_id),
    .write_data(write_data),
    .grant_idx(grant_idx),
    .pending(pending)
  );

  int total = 0;
  int bad = 0;
  exp_t q[$];

  logic          v[N];
  logic [RW-1:0] idv[N];
  logic [XL-1:0] dv[N];
  int            rr = 0;
  logic [RW-1:0] l_id = '0;
  logic [XL-1:0] l_d = '0;
  int            l_g = 0;
  bit            clr = 1'b0;

  task automatic step(input logic rst, input logic hd);
    logic [N-1:0] er;
    exp_t e;
    int w;
    @(negedge clk);
    rst_n = rst;
    hold = hd;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_id[i*RW +: RW] = idv[i];
      req_data[i*XL +: XL] = dv[i];
    end
    #2;
    w = -1;
    if (rst && !hd) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && v[(rr + k) % N]) w = (rr + k) % N;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    total++;
    if (req_ready !== er) begin
      bad++;
      $display("FAIL ready: got %b want %b", req_ready, er);
    end
    if (!rst) begin
      rr = 0;
      l_id = '0;
      l_d = '0;
      l_g = 0;
      e.en = 1'b0;
      e.id = '0;
      e.data = '0;
      e.g = '0;
      e.pend = '0;
    end else if (w >= 0) begin
      l_id = idv[w];
      l_d = dv[w];
      l_g = w;
      e.en = (l_id != '0);
      e.id = l_id;
      e.data = l_d;
      e.g = 2'(w);
      e.pend = e.en ? er : '0;
      rr = (w + 1) % N;
      if (clr) v[w] = 1'b0;
    end else begin
      e.en = 1'b0;
      e.id = l_id;
      e.data = l_d;
      e.g = 2'(l_g);
      e.pend = '0;
    end
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [RW-1:0] id,
                         input logic [XL-1:0] d);
    v[i] = 1'b1;
    idv[i] = id;
    dv[i] = d;
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({enable_write, write_id, write_data, grant_idx, pending} !==
            {e.en, e.id, e.data, e.g, e.pend}) begin
          bad++;
          $display("FAIL out: got en=%b id=%0d d=%h g=%0d p=%b want en=%b id=%0d d=%h g=%0d p=%b",
                   enable_write, write_id, write_data, grant_idx, pending,
                   e.en, e.id, e.data, e.g, e.pend);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      idv[i] = '0;
      dv[i] = '0;
    end
    // reset then idle
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    // single writer
    clr = 1'b1;
    set_req(0, 5'd5, 32'hDEADBEEF);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // write to x0
    set_req(1, 5'd0, 32'h1234);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // round robin, continuously valid
    clr = 1'b0;
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd3, 32'h33);
    repeat (6) step(1'b1, 1'b0);
    // hold mid-stream
    repeat (3) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    // reset mid-stream after a grant to requester 2
    v[0] = 1'b0;
    v[1] = 1'b0;
    set_req(2, 5'd7, 32'h77);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    repeat (3) step(1'b1, 1'b0);
    // randomized traffic
    clr = 1'b1;
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom);
        end
      end
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0));
    end
    step(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback sources: ALU, load/store unit and mul/div unit.
- Arbitrates round-robin, drops writes to x0, and registers the winning write for one cycle before driving the register file's enable_write/write_id/write_data.
- Sits between the execute-stage result producers and the register file.

Parameters:
- NREQ, 3, number of requesters (2..8).
- XLEN, 32, data width; must equal op_t width.
- RID_W, 5, register id width; must equal reg_id_t width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- hold  input  1  pipeline freeze; while 1, no new grant is issued.
- req_valid  input  NREQ  requester i has a result pending.
- req_id  input  NREQ*RID_W  destination register of requester i, packed, slice i at [i*RID_W +: RID_W].
- req_data  input  NREQ*XLEN  result of requester i, packed likewise.
- req_ready  output  NREQ  one-hot (or zero) acceptance; a transfer occurs when req_valid[i] && req_ready[i].
- enable_write  output  1  to register file; registered.
- write_id  output  RID_W  to register file; registered.
- write_data  output  XLEN  to register file; registered.
- grant_idx  output  $clog2(NREQ)  index of the requester whose write is on the outputs this cycle; registered.
- pending  output  NREQ  bit i = 1 when the output stage holds a nonzero-id write from requester i; lets issue logic detect a bypass source.

Behaviour:
- Reset (rst_n=0 at posedge): enable_write=0, write_id=0, write_data=0, grant_idx=0, pending=0, rr_ptr=0.
- req_ready is combinational from req_valid, rr_ptr and hold only. It must not depend on req_id or req_data.
- req_ready is forced to 0 while rst_n=0.
- Arbitration:
  - Search from rr_ptr upward, wrapping modulo NREQ.
  - The first i with req_valid[i]=1 wins and req_ready[i]=1; all other ready bits are 0.
  - No valid requester, or hold=1, gives req_ready=0.
- Pointer update:
  - On a transfer by requester w, rr_ptr <= (w+1) mod NREQ, wrapping from NREQ-1 to 0.
  - With no transfer, rr_ptr is unchanged.
- Output stage, 1-cycle latency:
  - A transfer at edge k drives write_id/write_data/grant_idx = the winner's values during cycle k+1.
  - enable_write = 1 iff the winner's id != 0.
  - A write to x0 is accepted (ready=1) but produces enable_write=0, pending=0. write_id=0 and write_data are still captured.
- With no transfer, enable_write <= 0 and pending <= 0. write_id, write_data and grant_idx hold their previous values.
- hold=1: no grant. The output stage still retires its current entry: enable_write drops to 0 next cycle. The register file is never written twice.
- The output stage is always free because the register file accepts every cycle. No backpressure from the register file exists.
- Fairness: a continuously valid requester is granted within NREQ cycles of hold being 0.
- Same destination id from two requesters: serialized in grant order. The later grant overwrites. No merging or reordering.
- A requester must keep req_valid, req_id and req_data stable until its transfer. The arbiter does not check this; behaviour otherwise is undefined.
- Reset mid-operation: an in-flight output-stage write is discarded (enable_write=0 next cycle) and rr_ptr returns to 0.
- Single clock; no combinational path from req_* inputs to enable_write, write_id, write_data or grant_idx.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then all req_valid=0 -> enable_write=0, pending=0, req_ready=0 every cycle.
- Single writer: req_valid=001, id=5, data=0xDEADBEEF -> req_ready=001 at cycle 0; cycle 1 enable_write=1, write_id=5, write_data=0xDEADBEEF, grant_idx=0, pending=001.
- Round-robin: all three valid continuously with ids 1, 2, 3 -> grants 0,1,2,0,1,2; write_id sequence 1,2,3,1,2,3 one cycle later.
- x0 drop: req_valid=010, id=0, data=0x1234 -> req_ready=010; next cycle enable_write=0, pending=000; rr_ptr advances to 2.
- Hold: all valid, hold=1 for 3 cycles mid-stream -> req_ready=000 during hold; enable_write=0 from the cycle after hold rises. Grant order resumes at the stored rr_ptr with no skip and no repeat.
- Reset mid-stream: transfer from requester 2 (id=7), rst_n=0 on the next edge -> enable_write=0 and pending=0 after that edge. The first grant after reset goes to requester 0 when all are valid.
